fifo_tx_feeder: RTL

Read-side consumer of the asynchronous FIFO, in the FIFO read clock domain (the UART TX domain). It pops one word at a time from the FIFO read port, presents it to the UART transmitter as a parallel word with a valid strobe, waits for the transmitter to accept and finish the frame, and then enforces a configurable idle gap before the next pop. It also counts accepted frames and flags a transmitter that never responds.

---
 rtl/fifo_tx_feeder.sv | 133 +++++++++++++
 1 files changed

// File: rtl/fifo_tx_feeder.sv
// Read-side FIFO consumer for the UART TX clock domain: pops one word, hands it
// to the transmitter with a valid strobe, waits out the frame and an idle gap.
module fifo_tx_feeder #(
  parameter int DATA_WIDTH   = 8,
  parameter int GAP_CYCLES   = 2,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  enable,
  input  logic                  rempty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rinc,
  input  logic                  tx_busy,
  output logic [DATA_WIDTH-1:0] tx_p_data,
  output logic                  tx_data_valid,
  output logic [7:0]            frame_cnt,
  output logic                  err_timeout
);

  localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [TW-1:0] TOUT_LAST = TW'(BUSY_TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_SEND      = 2'd1;
  localparam logic [1:0] S_WAIT_DONE = 2'd2;
  localparam logic [1:0] S_GAP       = 2'd3;

  // A zero-length gap skips the GAP state entirely so pop-to-pop spacing
  // stays SEND + WAIT_DONE + GAP_CYCLES + IDLE.
  localparam logic [1:0] S_AFTER = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;

  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic [TW-1:0]         tout_q, tout_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic                  pop;

  assign pop = (state_q == S_IDLE) & enable & ~rempty & ~tx_busy;

  // The FIFO pointer must not move while reset is held, whatever the state.
  assign rinc = pop & rrst_n;

  always_comb begin
    // NOTE: every next-state signal takes its hold value first so no path
    // through the case statement leaves one unassigned (no latches).
    state_d = state_q;
    data_d  = data_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    tout_d  = tout_q;
    gap_d   = gap_q;

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          data_d  = rdata;
          valid_d = 1'b1;
          tout_d  = '0;
          state_d = S_SEND;
        end
      end

      S_SEND: begin
        if (tx_busy) begin
          valid_d = 1'b0;
          cnt_d   = cnt_q + 8'd1;
          state_d = S_WAIT_DONE;
        end else if (tout_q == TOUT_LAST) begin
          // Transmitter never answered: drop the word, remember the fault.
          valid_d = 1'b0;
          err_d   = 1'b1;
          gap_d   = '0;
          state_d = S_AFTER;
        end else begin
          tout_d = tout_q + TW'(1);
        end
      end

      S_WAIT_DONE: begin
        if (!tx_busy) begin
          gap_d   = '0;
          state_d = S_AFTER;
        end
      end

      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
      tout_q  <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      tout_q  <= tout_d;
      gap_q   <= gap_d;
    end
  end

  assign tx_p_data     = data_q;
  assign tx_data_valid = valid_q;
  assign frame_cnt     = cnt_q;
  assign err_timeout   = err_q;

endmodule
